// File: rtl/cellrv32_package.sv
// Shared constants and types for the CELLRV32 reset controller.
package cellrv32_package;

  // Reset-controller register window: one 32-bit word.
  localparam logic [31:0] rstctrl_base_c = 32'hFFFF_FFB8;
  localparam int          rstctrl_size_c = 4;
  localparam int          rstctrl_hi_c   = 31;
  localparam int          rstctrl_lo_c   = $clog2(rstctrl_size_c);

  // Reset cause encodings.
  localparam logic [1:0] rcause_ext_c = 2'b00;
  localparam logic [1:0] rcause_wdt_c = 2'b01;
  localparam logic [1:0] rcause_dbg_c = 2'b10;
  localparam logic [1:0] rcause_sw_c  = 2'b11;

  // Write key that must accompany a software reset trigger.
  localparam logic [15:0] rstctrl_key_c = 16'hA5C3;

  // Reset sequencer states.
  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_HOLD  = 2'b01,
    S_RUN   = 2'b10
  } rst_state_t;

  // Internal request priority: watchdog > debugger > software.
  // External reset never reaches here; it clears the cause register directly.
  function automatic logic [1:0] rcause_sel(input logic wdt_req, input logic dbg_req);
    if (wdt_req) begin
      return rcause_wdt_c;
    end else if (dbg_req) begin
      return rcause_dbg_c;
    end
    return rcause_sw_c;
  endfunction

endpackage

// File: rtl/cellrv32_rst_sync.sv
// Async-assert / sync-deassert synchronizer for the external pad reset.
module cellrv32_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic rstn_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift a constant 1 in; clear the whole chain the moment the pad drops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rstn_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cellrv32_rst_ctrl.sv
// System reset controller: external reset synchronizer, reset stretcher FSM,
// reset-cause / reset-count tracking and a single bus-accessible status word.
module cellrv32_rst_ctrl
  import cellrv32_package::*;
#(
  parameter int RST_STRETCH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_ext_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic        wdt_rstn_i,
  input  logic        dbg_rstn_i,
  output logic        rstn_ext_o,
  output logic        rstn_int_o,
  output logic [1:0]  rcause_o
);

  localparam logic [7:0] STRETCH_C = 8'(RST_STRETCH);

  logic        rstn_sync;
  logic        acc_match;
  logic        wdt_req;
  logic        dbg_req;
  logic        sw_req;
  logic        any_req;
  logic [31:0] rdata_d;
  logic        unused_bits;

  rst_state_t  state_q;
  logic [7:0]  cnt_q;
  logic        rstn_int_q;
  logic [1:0]  cause_q;
  logic [7:0]  count_q;
  logic        ack_q;
  logic [31:0] data_q;

  cellrv32_rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_ext_i),
    .rstn_o (rstn_sync)
  );

  assign acc_match = (addr_i[rstctrl_hi_c:rstctrl_lo_c] == rstctrl_base_c[rstctrl_hi_c:rstctrl_lo_c]);
  assign wdt_req   = ~wdt_rstn_i;
  assign dbg_req   = ~dbg_rstn_i;
  assign sw_req    = wren_i & acc_match & (data_i[31:16] == rstctrl_key_c) & data_i[0];
  assign any_req   = wdt_req | dbg_req | sw_req;

  // Byte offset and unused data bits carry no meaning for this register.
  assign unused_bits = ^{addr_i[rstctrl_lo_c-1:0], data_i[15:1]};

  // Reset sequencer: the synchronized external reset drives it into S_RESET;
  // internal requests re-enter S_HOLD and keep reloading the stretch counter.
  always_ff @(posedge clk_i or negedge rstn_sync) begin
    if (!rstn_sync) begin
      state_q    <= S_RESET;
      cnt_q      <= STRETCH_C;
      rstn_int_q <= 1'b0;
      cause_q    <= rcause_ext_c;
      count_q    <= 8'd0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q <= S_HOLD;
          cnt_q   <= STRETCH_C;
        end
        S_HOLD: begin
          if (any_req) begin
            cnt_q <= STRETCH_C;
          end else if (cnt_q <= 8'd1) begin
            cnt_q      <= 8'd0;
            state_q    <= S_RUN;
            rstn_int_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_RUN: begin
          if (any_req) begin
            state_q    <= S_HOLD;
            cnt_q      <= STRETCH_C;
            rstn_int_q <= 1'b0;
            cause_q    <= rcause_sel(wdt_req, dbg_req);
            if (count_q != 8'hFF) begin
              count_q <= count_q + 8'd1;
            end
          end
        end
        default: begin
          state_q    <= S_RESET;
          rstn_int_q <= 1'b0;
        end
      endcase
    end
  end

  // Status word returned on a decoded read; zero otherwise.
  always_comb begin
    rdata_d = '0;
    if (rden_i && acc_match) begin
      rdata_d[1:0]  = cause_q;
      rdata_d[2]    = ~rstn_int_q;
      rdata_d[15:8] = count_q;
    end
  end

  // Bus response: one-cycle acknowledge and registered read data.
  always_ff @(posedge clk_i or negedge rstn_sync) begin
    if (!rstn_sync) begin
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= (rden_i | wren_i) & acc_match;
      data_q <= rdata_d;
    end
  end

  assign rstn_ext_o = rstn_sync;
  assign rstn_int_o = rstn_int_q;
  assign rcause_o   = cause_q;
  assign ack_o      = ack_q;
  assign data_o     = data_q;

endmodule

// File: tb/tb_cellrv32_rst_ctrl.sv
// Directed bench for the reset controller; edges are counted from the
// rstn_ext_i release and outputs are sampled 1 time unit after each edge.
module tb_cellrv32_rst_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF_FFB8;

  logic        clk_i = 1'b0;
  logic        rstn_ext_i;
  logic [31:0] addr_i;
  logic        rden_i;
  logic        wren_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        wdt_rstn_i;
  logic        dbg_rstn_i;
  logic        rstn_ext_o;
  logic        rstn_int_o;
  logic [1:0]  rcause_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  cellrv32_rst_ctrl dut (
    .clk_i      (clk_i),
    .rstn_ext_i (rstn_ext_i),
    .addr_i     (addr_i),
    .rden_i     (rden_i),
    .wren_i     (wren_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .wdt_rstn_i (wdt_rstn_i),
    .dbg_rstn_i (dbg_rstn_i),
    .rstn_ext_o (rstn_ext_o),
    .rstn_int_o (rstn_int_o),
    .rcause_o   (rcause_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    addr_i = a;
    rden_i = 1'b1;
    step();
    rden_i = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr_i = a;
    data_i = d;
    wren_i = 1'b1;
    step();
    wren_i = 1'b0;
    data_i = '0;
  endtask

  task automatic wdt_pulse();
    wdt_rstn_i = 1'b0;
    step();
    wdt_rstn_i = 1'b1;
  endtask

  // Called right after the edge that sampled a request: low there and for
  // three more edges, high on the fourth.
  task automatic expect_release(input string tag);
    chk({tag, " int_o trig"}, 32'(rstn_int_o), 32'd0);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("%s int_o +%0d", tag, j), 32'(rstn_int_o), 32'(j == 4));
    end
  endtask

  // Release the pad reset between edges; edge k is the k-th edge afterwards.
  task automatic release_ext(input string tag);
    rstn_ext_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("%s e%0d ext_o", tag, k), 32'(rstn_ext_o), 32'(k >= 2));
      chk($sformatf("%s e%0d int_o", tag, k), 32'(rstn_int_o), 32'(k >= 7));
    end
  endtask

  initial begin
    rstn_ext_i = 1'b0;
    addr_i     = '0;
    rden_i     = 1'b0;
    wren_i     = 1'b0;
    data_i     = '0;
    wdt_rstn_i = 1'b1;
    dbg_rstn_i = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst ext_o", 32'(rstn_ext_o), 32'd0);
    chk("rst int_o", 32'(rstn_int_o), 32'd0);
    chk("rst cause", 32'(rcause_o), 32'd0);
    chk("rst ack",   32'(ack_o), 32'd0);
    chk("rst data",  data_o, 32'd0);

    // Power-up release: ext_o at edge 2, int_o at edge 7
    release_ext("pwr");
    chk("pwr cause", 32'(rcause_o), 32'd0);

    // Watchdog pulse sampled at edge 20 (now at edge 8)
    repeat (11) step();
    wdt_pulse();
    expect_release("wdt");
    chk("wdt cause", 32'(rcause_o), 32'd1);
    bus_rd(BASE);
    chk("wdt rd ack",  32'(ack_o), 32'd1);
    chk("wdt rd data", data_o, 32'h0000_0101);
    step();
    chk("idle ack",  32'(ack_o), 32'd0);
    chk("idle data", data_o, 32'd0);

    // Debugger request held for 10 sampled edges
    dbg_rstn_i = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      step();
      chk($sformatf("dbg int_o +%0d", j), 32'(rstn_int_o), 32'(j >= 14));
      if (j == 10) dbg_rstn_i = 1'b1;
    end
    chk("dbg cause", 32'(rcause_o), 32'd2);

    // Simultaneous watchdog + debugger: watchdog wins
    wdt_rstn_i = 1'b0;
    dbg_rstn_i = 1'b0;
    step();
    wdt_rstn_i = 1'b1;
    dbg_rstn_i = 1'b1;
    expect_release("both");
    chk("both cause", 32'(rcause_o), 32'd1);

    // Keyed software trigger
    bus_wr(BASE, 32'hA5C3_0001);
    chk("sw ack", 32'(ack_o), 32'd1);
    expect_release("sw");
    chk("sw cause", 32'(rcause_o), 32'd3);

    // Wrong key, key without bit 0, key at another address: no reset
    bus_wr(BASE, 32'h1234_0001);
    chk("badkey ack",   32'(ack_o), 32'd1);
    chk("badkey int_o", 32'(rstn_int_o), 32'd1);
    bus_wr(BASE, 32'hA5C3_0000);
    chk("bit0 ack",     32'(ack_o), 32'd1);
    chk("bit0 int_o",   32'(rstn_int_o), 32'd1);
    bus_wr(BASE + 32'd4, 32'hA5C3_0001);
    chk("badaddr ack",  32'(ack_o), 32'd0);
    step();
    chk("badaddr int_o", 32'(rstn_int_o), 32'd1);
    chk("nochange cause", 32'(rcause_o), 32'd3);
    bus_rd(BASE);
    chk("sw rd data", data_o, 32'h0000_0403);

    // Counter saturation: 4 resets so far plus 256 more
    for (int i = 0; i < 256; i++) begin
      wdt_pulse();
      repeat (4) step();
    end
    chk("sat int_o", 32'(rstn_int_o), 32'd1);
    bus_rd(BASE);
    chk("sat rd data", data_o, 32'h0000_FF01);

    // External reset asserted mid-S_HOLD takes effect without a clock edge
    wdt_pulse();
    step();
    #2 rstn_ext_i = 1'b0;
    #1;
    chk("async ext_o", 32'(rstn_ext_o), 32'd0);
    chk("async int_o", 32'(rstn_int_o), 32'd0);
    chk("async cause", 32'(rcause_o), 32'd0);
    chk("async ack",   32'(ack_o), 32'd0);
    chk("async data",  data_o, 32'd0);
    repeat (2) step();
    release_ext("rel2");
    bus_rd(BASE);
    chk("rel2 rd ack",  32'(ack_o), 32'd1);
    chk("rel2 rd data", data_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cellrv32_rst_ctrl.md
CELLRV32_RST_CTRL -- requirements
Module: cellrv32_rst_ctrl

Interface
REQ-001 SHALL have parameter RST_STRETCH, default 4: number of cycles internal reset is held after the last request ends (range 1..255).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: external reset synchronizer depth (range 2..4).
REQ-003 SHALL have port clk_i  in  1  global clock; the only clock.
REQ-004 SHALL have port rstn_ext_i  in  1  external pad reset; asynchronous, active-low; the only reset.
REQ-005 SHALL have ports addr_i in 32, rden_i in 1, wren_i in 1, data_i in 32, data_o out 32, ack_o out 1: host bus access.
REQ-006 SHALL have port wdt_rstn_i  in  1  watchdog reset request; active-low, synchronous to clk_i.
REQ-007 SHALL have port dbg_rstn_i  in  1  on-chip-debugger reset request; active-low, synchronous to clk_i.
REQ-008 SHALL have port rstn_ext_o  out  1  synchronized external reset; async-assert, sync-deassert.
REQ-009 SHALL have port rstn_int_o  out  1  system-wide internal reset; registered, glitch-free.
REQ-010 SHALL have port rcause_o  out  2  cause of the last reset.

Function
REQ-011 SHALL assert rstn_ext_o asynchronously with rstn_ext_i and deassert it SYNC_STAGES rising edges after rstn_ext_i rises.
REQ-012 SHALL implement FSM states: S_RESET (ext reset active), S_HOLD (stretch counting), S_RUN.
REQ-013 SHALL drive rstn_int_o low in S_RESET and S_HOLD, and high only in S_RUN.
REQ-014 SHALL transition S_RESET -> S_HOLD on the first edge with synchronized reset high; stretch counter loads RST_STRETCH.
REQ-015 SHALL transition S_HOLD -> S_RUN when the counter reaches 0 with no request active; with defaults, rstn_int_o rises at edge SYNC_STAGES+1+RST_STRETCH = 7 after rstn_ext_i rises.
REQ-016 SHALL treat wdt_rstn_i=0, dbg_rstn_i=0, or a valid software trigger as an internal request; in S_RUN, a request sampled at edge n moves the FSM to S_HOLD and pulls rstn_int_o low from edge n.
REQ-017 SHALL reload the stretch counter every cycle a request is active in S_HOLD, so rstn_int_o rises RST_STRETCH edges after the last active cycle.
REQ-018 SHALL encode the cause as: 00 external, 01 watchdog, 10 debugger, 11 software.
REQ-019 SHALL resolve simultaneous requests by priority: external > watchdog > debugger > software.
REQ-020 SHALL latch the cause on each S_RUN -> S_HOLD entry, and SHALL NOT change it while in S_HOLD.
REQ-021 SHALL keep an 8-bit counter of internal resets, saturating at 255 and cleared only by rstn_ext_i.
REQ-022 SHALL decode its register when addr_i[hi:lo] equals rstctrl_base_c; ack_o is 1 on the edge after rden|wren (one-cycle latency).
REQ-023 SHALL return on read: data_o[1:0]=cause, [2]=internal reset pending (always 0 when read from software), [15:8]=reset count, others 0; data_o is 0 when not reading.
REQ-024 SHALL issue a software trigger only on a write with data_i[31:16]=16'hA5C3 and data_i[0]=1; any other write is acknowledged with no effect.
REQ-025 SHALL assert rstn_ext_i at any state, forcing S_RESET immediately and asynchronously.

Reset
REQ-026 On rstn_ext_i=0, SHALL set: state S_RESET, rstn_ext_o=0, rstn_int_o=0, cause=00, count=0, ack_o=0, data_o=0, stretch counter=RST_STRETCH.
REQ-027 SHALL NOT clear the cause or the count on internal resets; rstn_int_o SHALL NOT reset this block.

Structure
REQ-028 SHALL place rstctrl_base_c, rstctrl_size_c, the cause encodings and the key 16'hA5C3 in cellrv32_package.
REQ-029 SHALL place the async-assert/sync-deassert chain in sub-module cellrv32_rst_sync, parameterized by SYNC_STAGES.
REQ-030 SHALL use a package enum for the FSM states.

Verification
REQ-031 Release rstn_ext_i at edge 0 -> rstn_ext_o=1 at edge 2, rstn_int_o=1 at edge 7, rcause_o=00.
REQ-032 In S_RUN, pulse wdt_rstn_i=0 for 1 cycle at edge 20 -> rstn_int_o=0 from edge 20 to 24, high at edge 24, rcause_o=01, count=1.
REQ-033 Hold dbg_rstn_i=0 for 10 cycles -> rstn_int_o is low throughout and rises 4 edges after release; rcause_o=10.
REQ-034 Assert wdt_rstn_i=0 and dbg_rstn_i=0 in the same cycle -> rcause_o=01; then write 0xA5C30001 -> rcause_o=11; write 0x12340001 -> ack_o=1 and no reset.
REQ-035 Drive 256 watchdog resets -> count reads 255; assert rstn_ext_i mid-S_HOLD -> all outputs go to 0 immediately and count/cause reads 0 after release.
